// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: sequencer for the DE1-SoC seven-segment digits.
// Accepts a value and a mode over a valid/ready port and drives one value byte and one
// output enable per digit. Modes are static, blink and scroll.
// Optional leading-zero blanking: define HEX_LZ_BLANK_EN to add the SCAN state.
module hex_display_ctrl #(
    parameter int unsigned DIGITS       = 6,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned BLINK_TICKS  = 500,
    parameter int unsigned SCROLL_TICKS = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [31:0]         wr_value,
    input  logic [1:0]          wr_mode,
    output logic [8*DIGITS-1:0] digit_value,
    output logic [DIGITS-1:0]   digit_oe,
    output logic                busy
);

    localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TMAX = (BLINK_TICKS > SCROLL_TICKS) ? BLINK_TICKS : SCROLL_TICKS;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PrescLast  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BlinkLast  = TW'(BLINK_TICKS - 1);
    localparam logic [TW-1:0] ScrollLast = TW'(SCROLL_TICKS - 1);
    localparam logic [1:0]    ModeBlink  = 2'b01;
    localparam logic [1:0]    ModeScroll = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
`ifdef HEX_LZ_BLANK_EN
        StScan = 2'd2,
`endif
        StShow = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           val_q;
    logic [1:0]            mode_q;
    logic [PW-1:0]         presc_q;
    logic [TW-1:0]         tcnt_q;
    logic [TW-1:0]         tcnt_last;
    logic [2:0]            offset_q;
    logic                  phase_q;
    logic [8*DIGITS-1:0]   value_q;
    logic [DIGITS-1:0]     oe_q;
    logic                  accept;
    logic                  tick;
    logic                  commit;
    logic                  timed_mode;
    logic [DIGITS-1:0]     show_mask;
    logic [DIGITS-1:0]     commit_oe;

    // Digit i shows nibble (i+k) mod 8 of the latched value; upper nibble of each byte is 0.
    function automatic logic [8*DIGITS-1:0] rotated(input logic [31:0] v, input logic [2:0] k);
        logic [8*DIGITS-1:0] r;
        logic [2:0]          n;
        r = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            n = 3'(i) + k;
            r[8*i +: 8] = {4'h0, v[4*n +: 4]};
        end
        return r;
    endfunction

    assign wr_ready    = (state_q == StIdle) || (state_q == StShow);
    assign busy        = ~wr_ready;
    assign accept      = wr_valid & wr_ready;
    assign tick        = (state_q == StShow) && (presc_q == PrescLast);
    assign timed_mode  = (mode_q == ModeBlink) || (mode_q == ModeScroll);
    assign tcnt_last   = (mode_q == ModeBlink) ? BlinkLast : ScrollLast;
    assign digit_value = value_q;
    assign digit_oe    = oe_q;

`ifdef HEX_LZ_BLANK_EN
    localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SW-1:0]     scan_idx_q;
    logic              zero_run_q;
    logic [DIGITS-1:0] mask_q;
    logic [3:0]        scan_nib;
    logic              scan_lit;
    logic [DIGITS-1:0] scan_mask_d;

    // Blanking decision for the digit under scan; zero_run_q means every higher digit was 0.
    always_comb begin
        scan_nib    = val_q[4*scan_idx_q +: 4];
        scan_lit    = (scan_nib != 4'h0) || !zero_run_q || (scan_idx_q == '0) ||
                      (mode_q == ModeScroll);
        scan_mask_d = mask_q;
        scan_mask_d[scan_idx_q] = scan_lit;
    end

    assign commit    = (state_q == StScan) && (scan_idx_q == '0);
    assign commit_oe = scan_mask_d;
    assign show_mask = mask_q;
`else
    assign commit    = (state_q == StLoad);
    assign commit_oe = '1;
    assign show_mask = '1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept only from IDLE/SHOW, then LOAD (and SCAN) before SHOW.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StShow: if (accept) state_d = StLoad;
`ifdef HEX_LZ_BLANK_EN
            StLoad: state_d = StScan;
            StScan: if (scan_idx_q == '0) state_d = StShow;
`else
            StLoad: state_d = StShow;
`endif
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latch on accept, build blank mask in SCAN, commit, then run tick-driven effects.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q      <= '0;
            mode_q     <= '0;
            presc_q    <= '0;
            tcnt_q     <= '0;
            offset_q   <= '0;
            phase_q    <= 1'b0;
            value_q    <= '0;
            oe_q       <= '0;
`ifdef HEX_LZ_BLANK_EN
            scan_idx_q <= '0;
            zero_run_q <= 1'b0;
            mask_q     <= '0;
`endif
        end else if (accept) begin
            // Old outputs stay up until the new commit.
            val_q      <= wr_value;
            mode_q     <= wr_mode;
            presc_q    <= '0;
            tcnt_q     <= '0;
            offset_q   <= '0;
            phase_q    <= 1'b1;
`ifdef HEX_LZ_BLANK_EN
            scan_idx_q <= SW'(DIGITS - 1);
            zero_run_q <= 1'b1;
`endif
        end else begin
`ifdef HEX_LZ_BLANK_EN
            if (state_q == StScan) begin
                mask_q     <= scan_mask_d;
                zero_run_q <= zero_run_q && (scan_nib == 4'h0);
                if (scan_idx_q != '0) scan_idx_q <= scan_idx_q - SW'(1);
            end
`endif
            if (commit) begin
                value_q <= rotated(val_q, 3'd0);
                oe_q    <= commit_oe;
            end
            if (state_q == StShow) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick && timed_mode) begin
                    if (tcnt_q == tcnt_last) begin
                        tcnt_q <= '0;
                        if (mode_q == ModeBlink) begin
                            phase_q <= ~phase_q;
                            oe_q    <= phase_q ? '0 : show_mask;
                        end else begin
                            offset_q <= offset_q + 3'd1;
                            value_q  <= rotated(val_q, offset_q + 3'd1);
                        end
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
            end
        end
    end

endmodule
